mem_access_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl_latency_counter.sv | 37 +++
 rtl/mem_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_MEM_LATENCY = 2;
  localparam logic [1:0] MEM_WORD_ALIGN_MASK = 2'b11;

  // A word access is misaligned when either low byte-address bit is set.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & MEM_WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_latency_counter.sv
// 4-bit clear/increment counter that flags when it reaches the read latency.
// The count saturates at 15 so it can never wrap back to a false match.
module latency_counter #(
  parameter int unsigned TERMINAL = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic match
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear wins over increment, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (incr && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Count register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match = (cnt_q == TERMINAL[3:0]);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the control unit and a synchronous
// word memory. One access at a time; reads wait out the memory latency and
// misaligned addresses complete immediately without touching memory.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              misalign,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              we_q,       we_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              err_q,      err_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              ready_q,    ready_d;
  logic              done_q,     done_d;
  logic              misalign_q, misalign_d;
  logic              mem_wr_q,   mem_wr_d;

  logic cnt_clear;
  logic cnt_incr;
  logic cnt_match;

  latency_counter #(
    .TERMINAL (MEM_LATENCY)
  ) u_latency_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .match (cnt_match)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every handshake and memory strobe leaves the block registered.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    mem_wr_d   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_incr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req && ready_q) begin
          addr_d    = addr;
          we_d      = we;
          wdata_d   = wdata;
          cnt_clear = 1'b1;
          ready_d   = 1'b0;
          if (is_misaligned(addr[1:0])) begin
            err_d      = 1'b1;
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else if (we) begin
            state_d  = WRITE;
            mem_wr_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        cnt_incr = ~cnt_match;
        if (cnt_match && !we_q) begin
          rdata_d    = mem_rdata;
          state_d    = DONE;
          done_d     = 1'b1;
          misalign_d = err_q;
        end
      end

      WRITE: begin
        state_d    = DONE;
        done_d     = 1'b1;
        misalign_d = err_q;
      end

      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, captured request and registered outputs; reset abandons any
  // access in flight and clears the held load result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign rdata     = rdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: three instances (latency 2, 1, 4)
// share one request stream, each with its own latency-accurate memory.
module tb_mem_access_ctrl;

  localparam int N = 3;
  localparam int LAT [N] = '{2, 1, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        ready_o    [N];
  logic        done_o     [N];
  logic        misalign_o [N];
  logic        mem_wr_o   [N];
  logic [31:0] rdata_o     [N];
  logic [31:0] mem_addr_o  [N];
  logic [31:0] mem_wdata_o [N];
  logic [31:0] mem_rdata_i [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0][31:0] rdata;
    logic [N-1:0][7:0]  lat;
    logic               misalign;
    logic               wr;
    logic [31:0]        addr;
    logic [31:0]        wdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rd [N];

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int k);
    if (k == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(k) * 32'h0001_0011;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mem  [64];
    logic [31:0] pipe [4];
    logic        loaded = 1'b0;

    mem_access_ctrl #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MEM_LATENCY (LAT[g])
    ) u_dut (
      .clock     (clk),
      .reset     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ready     (ready_o[g]),
      .done      (done_o[g]),
      .misalign  (misalign_o[g]),
      .rdata     (rdata_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wr    (mem_wr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (mem_rdata_i[g])
    );

    // Synchronous word memory: preload once, write on mem_wr, and return the
    // word addressed LAT cycles earlier.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int k = 0; k < 64; k++) mem[k] <= pattern(k);
        loaded <= 1'b1;
      end else if (mem_wr_o[g]) begin
        mem[mem_addr_o[g][7:2]] <= mem_wdata_o[g];
      end
      pipe[0] <= mem_addr_o[g];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign mem_rdata_i[g] = mem[pipe[LAT[g]-1][7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s ready[%0d]", tag, g), 32'(ready_o[g]), 32'd1);
      check($sformatf("%s done[%0d]", tag, g), 32'(done_o[g]), 32'd0);
      check($sformatf("%s misalign[%0d]", tag, g), 32'(misalign_o[g]), 32'd0);
      check($sformatf("%s mem_wr[%0d]", tag, g), 32'(mem_wr_o[g]), 32'd0);
      check($sformatf("%s rdata[%0d]", tag, g), rdata_o[g], last_rd[g]);
    end
  endtask

  // Predict the outcome for every instance, queue it, then issue one request.
  task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic mis;
    mis = (a[1:0] != 2'b00);
    for (int g = 0; g < N; g++) begin
      e.lat[g] = mis ? 8'd1 : (w ? 8'd2 : 8'(LAT[g] + 2));
      if (!mis && !w) last_rd[g] = ref_mem[a[7:2]];
      e.rdata[g] = last_rd[g];
    end
    if (!mis && w) ref_mem[a[7:2]] = d;
    e.misalign = mis;
    e.wr       = !mis && w;
    e.addr     = a;
    e.wdata    = d;
    sb_q.push_back(e);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // Watch a bounded window after the accept edge and compare against the
  // oldest scoreboard entry once the latency-2 instance reports done.
  task automatic check_output(input string tag);
    int          done_at  [N];
    int          done_cnt [N];
    logic [31:0] obs_rd   [N];
    logic        obs_mis  [N];
    int          wr_cnt;
    int          wr_at;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    exp_t        e;
    bit          popped;
    wr_cnt  = 0;
    wr_at   = 0;
    wr_addr = '0;
    wr_data = '0;
    popped  = 1'b0;
    for (int g = 0; g < N; g++) begin
      done_at[g]  = 0;
      done_cnt[g] = 0;
      obs_rd[g]   = 'x;
      obs_mis[g]  = 1'bx;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (done_o[g] === 1'b1) begin
          done_cnt[g]++;
          if (done_cnt[g] == 1) begin
            done_at[g] = n;
            obs_rd[g]  = rdata_o[g];
            obs_mis[g] = misalign_o[g];
          end
        end
      end
      if (done_o[0] === 1'b1 && !popped && sb_q.size() > 0) begin
        e      = sb_q.pop_front();
        popped = 1'b1;
      end
      if (mem_wr_o[0] === 1'b1) begin
        wr_cnt++;
        wr_at   = n;
        wr_addr = mem_addr_o[0];
        wr_data = mem_wdata_o[0];
      end
    end
    if (!popped && sb_q.size() > 0) e = sb_q.pop_front();
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s done_count[%0d]", tag, g), 32'(done_cnt[g]), 32'd1);
      check($sformatf("%s done_cycle[%0d]", tag, g), 32'(done_at[g]), 32'(e.lat[g]));
      check($sformatf("%s rdata[%0d]", tag, g), obs_rd[g], e.rdata[g]);
      check($sformatf("%s misalign[%0d]", tag, g), 32'(obs_mis[g]), 32'(e.misalign));
    end
    check($sformatf("%s mem_wr_count", tag), 32'(wr_cnt), 32'(e.wr));
    if (e.wr) begin
      check($sformatf("%s mem_wr_cycle", tag), 32'(wr_at), 32'd1);
      check($sformatf("%s mem_addr", tag), wr_addr, e.addr);
      check($sformatf("%s mem_wdata", tag), wr_data, e.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int k = 0; k < 64; k++) ref_mem[k] = pattern(k);
    for (int g = 0; g < N; g++) last_rd[g] = '0;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_released");

    $display("[TB] aligned load");
    apply_stimulus(1'b0, 32'h10, 32'h0);
    check_output("load_10");

    $display("[TB] store then load");
    apply_stimulus(1'b1, 32'h20, 32'h12345678);
    check_output("store_20");
    apply_stimulus(1'b0, 32'h20, 32'h0);
    check_output("load_20");

    $display("[TB] misaligned accesses");
    apply_stimulus(1'b0, 32'h22, 32'h0);
    check_output("mis_load_22");
    apply_stimulus(1'b1, 32'h22, 32'hBAD0BAD0);
    check_output("mis_store_22");
    apply_stimulus(1'b0, 32'h20, 32'h0);
    check_output("reload_20");

    $display("[TB] busy: req held, addr changing");
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h10;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1 addr = 32'h40 + 32'(4 * n);
      @(negedge clk);
      if (n <= 4) check($sformatf("busy mem_addr c%0d", n), mem_addr_o[0], 32'h10);
      if (n <= 5) check($sformatf("busy done c%0d", n), 32'(done_o[0]), (n == 4) ? 32'd1 : 32'd0);
      if (n == 4) check("busy rdata", rdata_o[0], 32'hDEADBEEF);
      if (n == 5) check("busy ready_after_done", 32'(ready_o[0]), 32'd1);
      if (n == 6) begin
        check("busy reaccept ready", 32'(ready_o[0]), 32'd0);
        check("busy reaccept mem_addr", mem_addr_o[0], 32'h54);
      end
    end
    req = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] reset during read");
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h10;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) last_rd[g] = '0;
    check_idle("mid_reset");
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++)
        check($sformatf("mid_reset no_done[%0d]", g), 32'(done_o[g]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_mid_reset");

    $display("[TB] recovery and latency sweep");
    apply_stimulus(1'b0, 32'h14, 32'h0);
    check_output("load_14");
    apply_stimulus(1'b1, 32'h3C, 32'hCAFEF00D);
    check_output("store_3c");
    apply_stimulus(1'b0, 32'h3C, 32'h0);
    check_output("load_3c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
